// File: rtl/crypt_pkg.sv
// Shared types, frame geometry and LFSR step for the stream-cipher sequencer.
package crypt_pkg;

  localparam int unsigned MSG_LEN   = 41;
  localparam int unsigned FRAME_LEN = 64;
  localparam logic [7:0]  CFG_BASE  = 8'd41;
  localparam logic [7:0]  OUT_BASE  = 8'd64;
  localparam logic [7:0]  PAD_CHAR  = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    CFG,
    STEP_PAD,
    STEP_RD,
    STEP_WR,
    DONE
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] taps);
    return {s[6:0], ^(s & taps)};
  endfunction

  // Frame byte idx carries a message byte; 9-bit difference so nothing wraps.
  function automatic logic in_msg(input logic [7:0] idx, input logic [7:0] pre_len);
    logic [8:0] rel;
    rel = {1'b0, idx} - {1'b0, pre_len};
    return (idx >= pre_len) && (rel < 9'(MSG_LEN));
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci-style LFSR with synchronous load and advance.
module lfsr8
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  input  logic [7:0] taps,
  output logic [7:0] value
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      value <= 8'h00;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_next(value, taps);
    end
  end

endmodule

// File: rtl/crypt_seq_ctrl.sv
// Sequencer: fetches cipher config from data memory, then XORs the 64-byte
// padded frame with the rolling LFSR state and writes the result back.
module crypt_seq_ctrl
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic       mode,
  output logic       mem_req,
  input  logic       mem_gnt,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  state_t      state_q, state_d, step_next;
  logic        mode_q;
  logic        cfg_err_q;
  logic [5:0]  idx_q;
  logic [7:0]  pre_len_q;
  logic [7:0]  taps_q;
  logic [1:0]  cfg_cnt_q;
  logic [1:0]  cfg_tag_q;
  logic        rd_q;
  logic [7:0]  rd_hold_q;
  logic [7:0]  lfsr;

  logic        accept, cfg_issue, lfsr_load, lfsr_adv, idx_clr, idx_adv;
  logic [7:0]  idx8, out_addr, msg_addr, rd_data;
  logic        last_idx;

  lfsr8 u_lfsr (
    .clk     (clk),
    .init_n  (init_n),
    .load    (lfsr_load),
    .seed    (mem_rdata),
    .advance (lfsr_adv),
    .taps    (taps_q),
    .value   (lfsr)
  );

  assign idx8     = {2'b00, idx_q};
  assign out_addr = OUT_BASE + idx8;
  assign msg_addr = idx8 - pre_len_q;
  assign last_idx = (idx_q == 6'(FRAME_LEN - 1));
  // Read data is live the cycle after the strobe, otherwise held across a grant gap.
  assign rd_data  = rd_q ? mem_rdata : rd_hold_q;

  assign step_next = last_idx ? DONE
                   : (in_msg(idx8 + 8'd1, pre_len_q) ? STEP_RD : STEP_PAD);

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    accept    = 1'b0;
    cfg_issue = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    idx_clr   = 1'b0;
    idx_adv   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (mem_gnt) state_d = CFG;
      end
      CFG: begin
        if (mem_gnt && cfg_cnt_q != 2'd3) begin
          mem_rd_en = 1'b1;
          mem_addr  = CFG_BASE + {6'd0, cfg_cnt_q};
          cfg_issue = 1'b1;
        end
        // Seed arriving closes config; pre_len is already registered by now.
        if (rd_q && cfg_tag_q == 2'd2) begin
          lfsr_load = 1'b1;
          idx_clr   = 1'b1;
          state_d   = in_msg(8'd0, pre_len_q) ? STEP_RD : STEP_PAD;
        end
      end
      STEP_PAD: begin
        if (mem_gnt) begin
          if (!mode_q) begin
            mem_wr_en = 1'b1;
            mem_addr  = out_addr;
            mem_wdata = PAD_CHAR ^ lfsr;
          end
          lfsr_adv = 1'b1;
          idx_adv  = !last_idx;
          state_d  = step_next;
        end
      end
      STEP_RD: begin
        if (mem_gnt) begin
          mem_rd_en = 1'b1;
          mem_addr  = mode_q ? out_addr : msg_addr;
          state_d   = STEP_WR;
        end
      end
      STEP_WR: begin
        if (mem_gnt) begin
          mem_wr_en = 1'b1;
          mem_addr  = mode_q ? msg_addr : out_addr;
          mem_wdata = rd_data ^ lfsr;
          lfsr_adv  = 1'b1;
          idx_adv   = !last_idx;
          state_d   = step_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      idx_q     <= 6'd0;
      pre_len_q <= 8'h00;
      taps_q    <= 8'h00;
      cfg_cnt_q <= 2'd0;
      cfg_tag_q <= 2'd0;
      rd_q      <= 1'b0;
      rd_hold_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rd_q    <= mem_rd_en;
      if (accept) begin
        mode_q    <= mode;
        cfg_err_q <= 1'b0;
        cfg_cnt_q <= 2'd0;
      end
      if (cfg_issue) begin
        cfg_cnt_q <= cfg_cnt_q + 2'd1;
        cfg_tag_q <= cfg_cnt_q;
      end
      if (rd_q) rd_hold_q <= mem_rdata;
      if (rd_q && state_q == CFG) begin
        case (cfg_tag_q)
          2'd0:    pre_len_q <= mem_rdata;
          2'd1:    taps_q    <= mem_rdata;
          2'd2:    cfg_err_q <= (mem_rdata == 8'h00);
          default: ;
        endcase
      end
      if (idx_clr)      idx_q <= 6'd0;
      else if (idx_adv) idx_q <= idx_q + 6'd1;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign mem_req = busy;
  assign done    = (state_q == DONE);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_crypt_seq_ctrl.sv
// Directed bench for crypt_seq_ctrl: behavioural data memory plus a byte-level cipher model.
module tb_crypt_seq_ctrl;

  localparam int         MSGN   = 41;
  localparam int         FRAMEN = 64;
  localparam logic [7:0] PAD    = 8'h20;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       mem_gnt = 1'b1;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_req, mem_rd_en, mem_wr_en, busy, done, cfg_err;
  logic [7:0] mem_addr, mem_wdata;

  crypt_seq_ctrl dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
    .mode      (mode),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Data memory with a bench-side write port and strobe bookkeeping.
  logic [7:0] dmem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'h00;
  logic [7:0] tb_wd = 8'h00;
  int wr_count = 0, wr_low = 0, wr_out = 0, nognt = 0, dual = 0;

  always @(posedge clk) begin
    if (tb_we) dmem[tb_addr] <= tb_wd;
    if (mem_rd_en) mem_rdata <= dmem[mem_addr];
    if (mem_wr_en) begin
      dmem[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
      if (mem_addr <= 8'd40) wr_low <= wr_low + 1;
      if (mem_addr >= 8'd64 && mem_addr <= 8'd127) wr_out <= wr_out + 1;
    end
    if ((mem_rd_en || mem_wr_en) && !mem_gnt) nognt <= nognt + 1;
    if (mem_rd_en && mem_wr_en) dual <= dual + 1;
  end

  int passed = 0, fails = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] msg_b   [0:MSGN-1];
  logic [7:0] exp_out [0:FRAMEN-1];
  logic [7:0] golden  [0:FRAMEN-1];

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load_job(input logic [7:0] p, input logic [7:0] taps, input logic [7:0] seed);
    for (int i = 0; i < MSGN; i++) poke(8'(i), msg_b[i]);
    poke(8'd41, p);
    poke(8'd42, taps);
    poke(8'd43, seed);
    for (int i = 64; i < 128; i++) poke(8'(i), 8'hEE);
  endtask

  // Reference cipher: frame byte k uses LFSR state k, message placed after p pad bytes.
  task automatic build_expected(input logic [7:0] p, input logic [7:0] taps, input logic [7:0] seed);
    logic [7:0] s;
    s = seed;
    for (int k = 0; k < FRAMEN; k++) begin
      if (k >= int'(p) && k - int'(p) < MSGN) exp_out[k] = msg_b[k - int'(p)] ^ s;
      else                                    exp_out[k] = PAD ^ s;
      s = {s[6:0], ^(s & taps)};
    end
  endtask

  task automatic frame_mismatches(output int bad);
    bad = 0;
    for (int k = 0; k < FRAMEN; k++) if (dmem[64 + k] !== exp_out[k]) bad++;
  endtask

  // Pulse start, optionally drop grant for gap_len cycles at gap_at and pulse a
  // stray start (with flipped mode) at dup_at; returns cycles from accept to done.
  task automatic run_job(input string tag, input logic m, input int gap_at, input int gap_len,
                         input int dup_at, output int lat);
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on_start"}, {busy, mem_req, done}, 3'b110);
    lat = 0;
    while (!done && lat < 1000) begin
      mem_gnt = !(lat >= gap_at && lat < gap_at + gap_len);
      start   = (lat == dup_at);
      mode    = (lat == dup_at) ? ~m : m;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0; mode = m; mem_gnt = 1'b1;
    check({tag, "_done"}, {done, busy, mem_req}, 3'b100);
  endtask

  logic [8*MSGN-1:0] msg_vec;
  int lat, bad, w0, wl0, wo0, ng0, du0;

  initial begin
    msg_vec = "Meet me at the old mill at midnight sharp";
    for (int i = 0; i < MSGN; i++) msg_b[i] = msg_vec[8*(MSGN-1-i) +: 8];

    // Reset state
    #2;
    check("reset_outputs", {mem_req, mem_rd_en, mem_wr_en, busy, done, cfg_err, mem_addr, mem_wdata},
          22'd0);
    repeat (3) @(posedge clk);
    #1 init_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, done, mem_req}, 3'b000);

    // Encrypt, pre_len 9, taps B4, seed 40
    load_job(8'd9, 8'hB4, 8'h40);
    build_expected(8'd9, 8'hB4, 8'h40);
    w0 = wr_count; wo0 = wr_out; ng0 = nognt; du0 = dual;
    run_job("enc9", 1'b0, 0, 0, -1, lat);
    check("enc9_latency", lat, 110);
    check("enc9_byte64", dmem[64], 8'h60);
    check("enc9_byte65", dmem[65], 8'hA0);
    check("enc9_byte66", dmem[66], 8'h21);
    check("enc9_byte73", dmem[73], 8'hD9);
    frame_mismatches(bad);
    check("enc9_frame_mismatches", bad, 0);
    check("enc9_writes_in_out", {wr_count - w0, wr_out - wo0}, {32'd64, 32'd64});
    check("enc9_cfg_err", cfg_err, 1'b0);
    check("enc9_strobe_rules", {nognt - ng0, dual - du0}, 64'd0);
    for (int k = 0; k < FRAMEN; k++) golden[k] = dmem[64 + k];

    // Same job with a 5-cycle grant gap mid-message and a stray start while busy
    for (int i = 64; i < 128; i++) poke(8'(i), 8'hEE);
    ng0 = nognt; w0 = wr_count;
    run_job("gap", 1'b0, 30, 5, 50, lat);
    check("gap_latency", lat, 115);
    check("gap_no_strobes_without_grant", nognt - ng0, 0);
    bad = 0;
    for (int k = 0; k < FRAMEN; k++) if (dmem[64 + k] !== golden[k]) bad++;
    check("gap_matches_uninterrupted", bad, 0);
    check("gap_write_count", wr_count - w0, 64);

    // Decrypt the stored ciphertext back into 0..40
    for (int i = 0; i < MSGN; i++) poke(8'(i), 8'h00);
    w0 = wr_count; wl0 = wr_low;
    run_job("dec", 1'b1, 0, 0, -1, lat);
    check("dec_latency", lat, 110);
    bad = 0;
    for (int i = 0; i < MSGN; i++) if (dmem[i] !== msg_b[i]) bad++;
    check("dec_plaintext_mismatches", bad, 0);
    check("dec_writes_only_low", {wr_count - w0, wr_low - wl0}, {32'd41, 32'd41});

    // pre_len 30: tail of the message falls off the frame
    load_job(8'd30, 8'hB4, 8'h40);
    build_expected(8'd30, 8'hB4, 8'h40);
    w0 = wr_count; wo0 = wr_out;
    run_job("p30", 1'b0, 0, 0, -1, lat);
    check("p30_latency", lat, 103);
    frame_mismatches(bad);
    check("p30_frame_mismatches", bad, 0);
    check("p30_writes_in_out", {wr_count - w0, wr_out - wo0}, {32'd64, 32'd64});

    // Zero seed: LFSR stays zero, cfg_err flags it, job still completes
    load_job(8'd9, 8'hB4, 8'h00);
    build_expected(8'd9, 8'hB4, 8'h00);
    run_job("seed0", 1'b0, 0, 0, -1, lat);
    check("seed0_cfg_err", cfg_err, 1'b1);
    check("seed0_pad_byte", dmem[64], 8'h20);
    check("seed0_msg_byte", dmem[73], 8'h4D);
    frame_mismatches(bad);
    check("seed0_frame_mismatches", bad, 0);

    // Reset mid-job
    poke(8'd43, 8'h40);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_cfg_err_cleared", {busy, cfg_err, done}, 3'b100);
    repeat (40) @(posedge clk);
    #1 init_n = 1'b0;
    #1;
    check("abort_outputs_zero", {mem_req, mem_rd_en, mem_wr_en, busy, done, cfg_err, mem_addr, mem_wdata},
          22'd0);
    w0 = wr_count;
    repeat (3) @(posedge clk);
    #1 init_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_writes_after", wr_count - w0, 0);
    check("abort_stays_idle", {busy, done, mem_req}, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
